// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing the single register-file read port among NREQ requesters.
// Grants one read per cycle, registers the address, and returns data two cycles after the grant.
module regread_arbiter #(
    parameter int NREQ     = 4,
    parameter int ADDRW    = 5,
    parameter int DATAW    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDRW-1:0]  req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [ADDRW-1:0]       rf_addr,
    input  logic [DATAW-1:0]       rf_data,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATAW-1:0]       resp_data
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic             a_valid_q, a_valid_d;
    logic [PTRW-1:0]  a_id_q, a_id_d;
    logic [ADDRW-1:0] rf_addr_q, rf_addr_d;
    logic             a_zero_q, a_zero_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATAW-1:0] resp_data_q, resp_data_d;

    logic             hi_found, lo_found, grant_found;
    logic [PTRW-1:0]  hi_idx, lo_idx, grant_idx;
    logic [ADDRW-1:0] grant_addr;

    // Handshake: a read is accepted in the cycle req_valid[i] & req_ready[i];
    // req_ready is one-hot or zero and never depends on anything but
    // stall, req_valid and the pointer. Responses carry no backpressure.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan leaves the lowest index at/above ptr (hi) and below ptr (lo).
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (PTRW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PTRW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PTRW'(i);
                end
            end
        end
        grant_found = !stall && (hi_found || lo_found);
        grant_idx   = hi_found ? hi_idx : lo_idx;

        grant_addr = '0;
        req_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PTRW'(i)) begin
                grant_addr   = req_addr[i*ADDRW +: ADDRW];
                req_ready[i] = grant_found;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            ptr_d = (grant_idx == PTRW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        a_valid_d = grant_found;
        a_id_d    = grant_idx;
        rf_addr_d = grant_found ? grant_addr : rf_addr_q;
        a_zero_d  = grant_found && (grant_addr == ADDRW'(ZERO_REG));

        resp_valid_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (a_id_q == PTRW'(i)) begin
                resp_valid_d[i] = a_valid_q;
            end
        end

        resp_data_d = resp_data_q;
        if (a_valid_q) begin
            resp_data_d = a_zero_q ? '0 : rf_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            a_valid_q    <= 1'b0;
            a_id_q       <= '0;
            rf_addr_q    <= '0;
            a_zero_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            a_valid_q    <= a_valid_d;
            a_id_q       <= a_id_d;
            rf_addr_q    <= rf_addr_d;
            a_zero_q     <= a_zero_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign rf_addr    = rf_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: directed scenarios plus random traffic, checked against
// a queue-based model of round-robin grants and 2-cycle responses.
module tb_regread_arbiter;

    localparam int NREQ     = 4;
    localparam int ADDRW    = 5;
    localparam int DATAW    = 64;
    localparam int ZERO_REG = 31;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  stall = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*ADDRW-1:0] req_addr = '0;
    logic [NREQ-1:0]       req_ready;
    logic [ADDRW-1:0]      rf_addr;
    logic [DATAW-1:0]      rf_data;
    logic [NREQ-1:0]       resp_valid;
    logic [DATAW-1:0]      resp_data;

    logic [DATAW-1:0] rf_table [32];
    assign rf_data = rf_table[rf_addr];

    always #5 clk = ~clk;

    regread_arbiter #(
        .NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .resp_valid(resp_valid), .resp_data(resp_data)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int               m_ptr;
    int               cyc = 0;
    int               due_q[$];
    int               id_q[$];
    logic [DATAW-1:0] exp_q[$];
    logic [ADDRW-1:0] m_rf_addr;
    logic [DATAW-1:0] m_last_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr       = 0;
        m_rf_addr   = '0;
        m_last_data = '0;
        due_q.delete();
        id_q.delete();
        exp_q.delete();
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*ADDRW-1:0] a,
                        input logic s, input logic r);
        int               g;
        logic [NREQ-1:0]  exp_ready;
        logic [NREQ-1:0]  exp_rv;
        logic [DATAW-1:0] exp_rd;
        logic [ADDRW-1:0] ga;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        stall     = s;
        reset     = r;
        #1;
        if (r) model_reset();
        g = s ? -1 : model_grant(v);
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        exp_rv = '0;
        exp_rd = m_last_data;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_rv      = NREQ'(1) << id_q[0];
            exp_rd      = exp_q[0];
            m_last_data = exp_rd;
            void'(due_q.pop_front());
            void'(id_q.pop_front());
            void'(exp_q.pop_front());
        end
        check_eq("req_ready",  64'(req_ready),  64'(exp_ready));
        check_eq("rf_addr",    64'(rf_addr),    64'(m_rf_addr));
        check_eq("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check_eq("resp_data",  64'(resp_data),  64'(exp_rd));
        if (g >= 0 && !r) begin
            ga = a[g*ADDRW +: ADDRW];
            due_q.push_back(cyc + 2);
            id_q.push_back(g);
            exp_q.push_back((int'(ga) == ZERO_REG) ? '0 : rf_table[ga]);
            m_rf_addr = ga;
            m_ptr     = (g + 1) % NREQ;
        end
        cyc++;
    endtask

    function automatic logic [NREQ*ADDRW-1:0] rand_addrs();
        logic [NREQ*ADDRW-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i*ADDRW +: ADDRW] = ADDRW'($urandom_range(0, 31));
        return r;
    endfunction

    function automatic logic [NREQ*ADDRW-1:0] addrs_with(input int idx, input int addr);
        logic [NREQ*ADDRW-1:0] r;
        r = rand_addrs();
        r[idx*ADDRW +: ADDRW] = ADDRW'(addr);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, rand_addrs(), 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_table[i] = DATAW'(i * 3);
        rf_table[ZERO_REG] = 64'hDEAD;
        model_reset();

        // Power-on reset, a little traffic, then reset again mid-run
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step(4'b1011, rand_addrs(), 1'b0, 1'b0);
        step(4'b0110, rand_addrs(), 1'b0, 1'b0);
        step('0, rand_addrs(), 1'b0, 1'b1);
        step('0, rand_addrs(), 1'b0, 1'b1);

        // Single read of register 7 (returns 21)
        step(4'b0001, addrs_with(0, 7), 1'b0, 1'b0);
        idle(3);

        // Round-robin rotation with all requesters valid
        for (int i = 0; i < 8; i++) step(4'b1111, rand_addrs(), 1'b0, 1'b0);
        idle(2);

        // Skip and wrap: grant to 1 (ptr=2), then 0011 wraps to 0, then 1
        step(4'b0010, rand_addrs(), 1'b0, 1'b0);
        step(4'b0011, rand_addrs(), 1'b0, 1'b0);
        step(4'b0011, rand_addrs(), 1'b0, 1'b0);
        idle(2);

        // Zero register reads as 0 even though the file holds 0xDEAD
        step(4'b0100, addrs_with(2, ZERO_REG), 1'b0, 1'b0);
        idle(3);

        // Stall: in-flight read completes, pointer unchanged
        step(4'b0001, rand_addrs(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1111, rand_addrs(), 1'b1, 1'b0);
        step(4'b1111, rand_addrs(), 1'b0, 1'b0);
        idle(3);

        // Reset with two reads in flight
        step(4'b1111, rand_addrs(), 1'b0, 1'b0);
        step(4'b1111, rand_addrs(), 1'b0, 1'b1);
        idle(2);
        step(4'b1111, rand_addrs(), 1'b0, 1'b0);
        idle(3);

        // Random traffic over a random register image
        for (int i = 0; i < 32; i++) rf_table[i] = {32'($urandom), 32'($urandom)};
        for (int i = 0; i < 400; i++) begin
            step(NREQ'($urandom), rand_addrs(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
